// File: rtl/synapse_pkg.sv
// Types and constants shared by the synapse blocks.
// No logic here: state encoding, drop counter width and the reset delay.
package synapse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        FIRE
    } syn_state_t;

    localparam int DROP_CNT_W    = 8;
    localparam int DEFAULT_DELAY = 3;

endpackage

// File: rtl/spike_rr_arbiter.sv
// Round-robin pick among pending spike sources, starting at rr_ptr and wrapping.
// Purely combinational, zero latency; no backpressure (caller decides when to take).
module spike_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    always_comb begin
        int          c;
        logic [IW-1:0] ci;
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int k = 0; k < N; k++) begin
            c  = (int'(rr_ptr) + k) % N;
            ci = IW'(c);
            if (!valid && req[ci]) begin
                valid = 1'b1;
                idx   = ci;
            end
        end
    end

endmodule

// File: rtl/synapse_scheduler.sv
// Shares one delay unit among N_SYN spike sources; emits each queued spike after its delay.
// Edge-to-pulse latency d+1 cycles, service d+2; one pending slot per source, overruns counted.
module synapse_scheduler
    import synapse_pkg::*;
#(
    parameter int N_SYN         = 4,
    parameter int DELAY_W       = 2,
    parameter int DEFAULT_DELAY = synapse_pkg::DEFAULT_DELAY
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SYN-1:0]         spike_in,
    input  logic                     cfg_we,
    input  logic [$clog2(N_SYN)-1:0] cfg_idx,
    input  logic [DELAY_W-1:0]       cfg_delay,
    input  logic                     cfg_en,
    output logic [N_SYN-1:0]         spike_out,
    output logic                     busy,
    output logic [$clog2(N_SYN)-1:0] grant_idx,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    localparam int IW = $clog2(N_SYN);

    syn_state_t         state, state_nxt;
    logic [N_SYN-1:0]   prev;
    logic [N_SYN-1:0]   pending, pending_nxt;
    logic [N_SYN-1:0]   en_r;
    logic [DELAY_W-1:0] delay_r [N_SYN];
    logic [DELAY_W-1:0] cnt;
    logic [IW-1:0]      rr_ptr;

    logic [N_SYN-1:0]   edge_det, grant_clr, cfg_clr, drop_vec, fire_vec;
    logic               arb_vld, take, cfg_hit;
    logic [IW-1:0]      arb_idx, fire_idx;

    spike_rr_arbiter #(.N(N_SYN)) u_arb (
        .req    (pending & en_r),
        .rr_ptr (rr_ptr),
        .valid  (arb_vld),
        .idx    (arb_idx)
    );

    assign edge_det = spike_in & ~prev & en_r;
    assign cfg_hit  = cfg_we && (int'(cfg_idx) < N_SYN);

    // A new edge beats the grant's clear (no drop); a disable write beats everything.
    always_comb begin
        grant_clr = '0;
        cfg_clr   = '0;
        if (take)
            grant_clr[arb_idx] = 1'b1;
        if (cfg_hit && !cfg_en)
            cfg_clr[cfg_idx] = 1'b1;
        drop_vec    = edge_det & pending & ~grant_clr & ~cfg_clr;
        pending_nxt = ((pending & ~grant_clr) | edge_det) & ~cfg_clr;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    take      = 1'b1;
                    state_nxt = (delay_r[arb_idx] != '0) ? DELAY : FIRE;
                end
            end
            DELAY: begin
                if (cnt == DELAY_W'(1))
                    state_nxt = FIRE;
            end
            FIRE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-delay grants go straight to FIRE before grant_idx is updated.
    always_comb begin
        fire_idx           = take ? arb_idx : grant_idx;
        fire_vec           = '0;
        fire_vec[fire_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            pending   <= '0;
            cnt       <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            spike_out <= '0;
            busy      <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            prev    <= spike_in;
            pending <= pending_nxt;
            if (take) begin
                grant_idx <= arb_idx;
                cnt       <= delay_r[arb_idx];
            end else if (state == DELAY) begin
                cnt <= cnt - DELAY_W'(1);
            end
            if (state == FIRE)
                rr_ptr <= (grant_idx == IW'(N_SYN - 1)) ? '0 : grant_idx + IW'(1);
            spike_out <= (state_nxt == FIRE) ? fire_vec : '0;
            busy      <= (state_nxt != IDLE);
            if (|drop_vec && drop_cnt != '1)
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SYN; i++)
                delay_r[i] <= DELAY_W'(DEFAULT_DELAY);
            en_r <= '1;
        end else if (cfg_hit) begin
            delay_r[cfg_idx] <= cfg_delay;
            en_r[cfg_idx]    <= cfg_en;
        end
    end

endmodule

// File: tb/tb_synapse_scheduler.sv
// Directed bench for synapse_scheduler: latency, fairness, config, overrun, set-beats-clear, reset.
module tb_synapse_scheduler;

    localparam int N  = 4;
    localparam int DW = 2;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  spike_in = '0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [DW-1:0] cfg_delay = '0;
    logic          cfg_en = 1'b0;
    logic [N-1:0]  spike_out;
    logic          busy;
    logic [IW-1:0] grant_idx;
    logic [7:0]    drop_cnt;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int busy_cyc = 0;
    int e0;
    int p_cyc[$];
    logic [N-1:0] p_vec[$];

    synapse_scheduler #(.N_SYN(N), .DELAY_W(DW), .DEFAULT_DELAY(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .spike_in  (spike_in),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_delay (cfg_delay),
        .cfg_en    (cfg_en),
        .spike_out (spike_out),
        .busy      (busy),
        .grant_idx (grant_idx),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every output pulse with the index of the clock edge that launched it.
    always @(negedge clk) begin
        if (!reset) begin
            if (spike_out != '0) begin
                p_cyc.push_back(cyc);
                p_vec.push_back(spike_out);
            end
            if (busy)
                busy_cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pc(input int i);
        return (i < p_cyc.size()) ? p_cyc[i] : -1;
    endfunction

    function automatic logic [N-1:0] pv(input int i);
        return (i < p_vec.size()) ? p_vec[i] : 4'hf;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        p_cyc.delete();
        p_vec.delete();
        busy_cyc = 0;
    endtask

    task automatic do_reset();
        spike_in = '0;
        cfg_we   = 1'b0;
        reset    = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        clear_log();
    endtask

    task automatic drive(input logic [N-1:0] v);
        spike_in = v;
        tick(1);
    endtask

    task automatic cfg_write(input logic [IW-1:0] idx, input logic [DW-1:0] d, input logic en);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_delay = d;
        cfg_en    = en;
        tick(1);
        cfg_we = 1'b0;
    endtask

    initial begin
        // Reset state and single spike with default delay 3
        do_reset();
        check("rst_spike_out", spike_out, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        e0 = cyc + 1;
        drive(4'b0100);
        drive(4'b0000);
        tick(10);
        check("single_count", p_cyc.size(), 1);
        check("single_vec", pv(0), 4'b0100);
        check("single_latency", pc(0) - e0, 4);
        check("single_busy_cycles", busy_cyc, 4);
        check("single_grant_idx", grant_idx, 2);
        check("single_busy_end", busy, 0);

        // Fairness: sources 0,1,3 together, rr_ptr starts at 0
        do_reset();
        e0 = cyc + 1;
        drive(4'b1011);
        drive(4'b0000);
        tick(20);
        check("fair_count", p_cyc.size(), 3);
        check("fair_vec0", pv(0), 4'b0001);
        check("fair_vec1", pv(1), 4'b0010);
        check("fair_vec2", pv(2), 4'b1000);
        check("fair_lat0", pc(0) - e0, 4);
        check("fair_gap01", pc(1) - pc(0), 5);
        check("fair_gap12", pc(2) - pc(1), 5);
        check("fair_drop", drop_cnt, 0);

        // Zero delay on source 1, then disable it
        cfg_write(2'd1, 2'd0, 1'b1);
        tick(2);
        clear_log();
        e0 = cyc + 1;
        drive(4'b0010);
        drive(4'b0000);
        tick(5);
        check("zero_count", p_cyc.size(), 1);
        check("zero_vec", pv(0), 4'b0010);
        check("zero_latency", pc(0) - e0, 1);
        cfg_write(2'd1, 2'd0, 1'b0);
        clear_log();
        drive(4'b0010);
        drive(4'b0000);
        tick(8);
        check("disabled_count", p_cyc.size(), 0);
        check("disabled_busy", busy_cyc, 0);

        // Overrun: three edges on source 0 while source 1 is in service
        do_reset();
        e0 = cyc + 1;
        drive(4'b0010);
        drive(4'b0001);
        drive(4'b0000);
        drive(4'b0001);
        drive(4'b0000);
        drive(4'b0001);
        drive(4'b0000);
        tick(12);
        check("overrun_count", p_cyc.size(), 2);
        check("overrun_vec0", pv(0), 4'b0010);
        check("overrun_lat0", pc(0) - e0, 4);
        check("overrun_vec1", pv(1), 4'b0001);
        check("overrun_lat1", pc(1) - e0, 9);
        check("overrun_drop", drop_cnt, 2);
        for (int i = 0; i < 310; i++) begin
            drive(4'b1111);
            drive(4'b0000);
        end
        check("overrun_saturate", drop_cnt, 255);

        // Set beats clear: source 2 re-edges in the very cycle it is granted
        do_reset();
        e0 = cyc + 1;
        drive(4'b0110);
        repeat (5) drive(4'b0000);
        drive(4'b0100);
        drive(4'b0000);
        tick(16);
        check("sbc_count", p_cyc.size(), 3);
        check("sbc_vec0", pv(0), 4'b0010);
        check("sbc_vec1", pv(1), 4'b0100);
        check("sbc_vec2", pv(2), 4'b0100);
        check("sbc_lat1", pc(1) - e0, 9);
        check("sbc_lat2", pc(2) - e0, 14);
        check("sbc_drop", drop_cnt, 0);

        // Async reset in the middle of DELAY with another spike still pending
        do_reset();
        cfg_write(2'd3, 2'd1, 1'b1);
        drive(4'b0011);
        drive(4'b0000);
        tick(1);
        check("arst_pre_busy", busy, 1);
        check("arst_pre_pending", dut.pending, 4'b0010);
        #2;
        reset = 1'b1;
        #1;
        check("arst_spike_out", spike_out, 0);
        check("arst_busy", busy, 0);
        check("arst_pending", dut.pending, 0);
        tick(2);
        reset = 1'b0;
        clear_log();
        tick(12);
        check("arst_no_pulse", p_cyc.size(), 0);
        for (int i = 0; i < N; i++)
            check($sformatf("arst_delay%0d", i), dut.delay_r[i], 3);
        check("arst_en", dut.en_r, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
